// File: rtl/im_loader.sv
// im_loader: boot-time instruction memory writer.
// Decodes framed byte segments (sync, base, count, data, checksum), writes
// big-endian 32-bit words into IM and releases the CPU after a go frame.
module im_loader #(
    parameter logic [31:0] TEXT_STARTADDR = 32'h0000_3000,
    parameter int unsigned IM_SIZE_WORD   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    // Wide enough that base + 4*N never wraps, even for N = 2^32-1.
    localparam int unsigned CW = 35;
    localparam logic [CW-1:0] IM_LO = CW'(TEXT_STARTADDR);
    localparam logic [CW-1:0] IM_HI = IM_LO + (CW'(IM_SIZE_WORD) << 2);
    localparam logic [7:0]    SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_CSUM,
        S_ERR,
        S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] base;
    logic [31:0] n;
    logic [31:0] k;
    logic [23:0] word;
    logic [7:0]  xsum;

    logic          accept;
    logic [31:0]   n_next;
    logic [CW-1:0] frame_end;
    logic          hdr_bad;

    // Handshake and header range check on the word count being completed.
    always_comb begin
        accept    = in_valid && in_ready;
        n_next    = {n[23:0], in_data};
        frame_end = CW'(base) + (CW'(n_next) << 2);
        hdr_bad   = (base[1:0] != 2'b00) || (CW'(base) < IM_LO) || (frame_end > IM_HI);
    end

    // Frame decoder, word assembly and registered IM write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            base     <= 32'd0;
            n        <= 32'd0;
            k        <= 32'd0;
            word     <= 24'd0;
            xsum     <= 8'd0;
            in_ready <= 1'b1;
            we       <= 1'b0;
            waddr    <= 32'd0;
            wdata    <= 32'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == SYNC) begin
                            state <= S_ADDR;
                            cnt   <= 2'd0;
                            xsum  <= 8'd0;
                            k     <= 32'd0;
                        end
                    end
                    S_ADDR: begin
                        base <= {base[23:0], in_data};
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        n   <= n_next;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (n_next == 32'd0) begin
                                state <= S_CSUM;
                            end else if (hdr_bad) begin
                                state    <= S_ERR;
                                err      <= 1'b1;
                                in_ready <= 1'b0;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        word <= {word[15:0], in_data};
                        xsum <= xsum ^ in_data;
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            we    <= 1'b1;
                            waddr <= base + {k[29:0], 2'b00};
                            wdata <= {word, in_data};
                            k     <= k + 32'd1;
                            if (k == n - 32'd1) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (in_data != xsum) begin
                            state    <= S_ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (n == 32'd0) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            in_ready <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: frames built from random words, expected
// writes and outcome derived from the frame rules (range, checksum, go frame).
module tb_im_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    im_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int  n_chk;
    int  n_fail;
    wr_t got_q[$];
    wr_t exp_q[$];
    logic prev_we;
    int   we_double;
    logic [31:0] none[$];

    // Collect every write; a high strobe on two consecutive cycles is illegal.
    always @(negedge clk) begin
        if (we === 1'b1) got_q.push_back('{waddr, wdata});
        if (we === 1'b1 && prev_we === 1'b1) we_double++;
        prev_we = we;
    end

    // Reference: IM spans [0x3000, 0x7000); base aligned; no wrap.
    function automatic bit hdr_ok(input logic [31:0] base, input logic [31:0] n);
        longint lo, hi, e;
        lo = 64'h3000;
        hi = 64'h3000 + 4 * 4096;
        e  = longint'(base) + 4 * longint'(n);
        return (base % 4 == 0) && (longint'(base) >= lo) && (e <= hi);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        we_double = 0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input logic [31:0] n,
                              input logic [31:0] words[$], input logic [7:0] delta,
                              input int max_gap);
        logic [7:0]  xs;
        logic [7:0]  b;
        logic [31:0] w;
        logic [31:0] a;
        bit          hdr_fail;
        bit          cs_fail;
        xs       = 8'h00;
        hdr_fail = (n != 0) && !hdr_ok(base, n);
        cs_fail  = (delta != 8'h00);
        drive_byte(8'hA5, int'($urandom_range(max_gap, 0)));
        for (int i = 3; i >= 0; i--) begin
            b = base[8*i +: 8];
            drive_byte(b, int'($urandom_range(max_gap, 0)));
        end
        for (int i = 3; i >= 0; i--) begin
            b = n[8*i +: 8];
            drive_byte(b, int'($urandom_range(max_gap, 0)));
        end
        if (n != 0) begin
            n_chk++;
            if (err !== hdr_fail) begin
                n_fail++;
                $display("FAIL header_err base=%h n=%h: got %b want %b", base, n, err, hdr_fail);
            end
        end
        if (hdr_fail) begin
            n_chk++;
            if (in_ready !== 1'b0 || cpu_hold !== 1'b1 || got_q.size() != 0) begin
                n_fail++;
                $display("FAIL header_err_state: in_ready=%b cpu_hold=%b writes=%0d want 0 1 0",
                         in_ready, cpu_hold, got_q.size());
            end
            return;
        end
        for (int unsigned j = 0; j < n; j++) begin
            w = words[j];
            for (int i = 3; i >= 0; i--) begin
                b  = w[8*i +: 8];
                xs = xs ^ b;
                drive_byte(b, int'($urandom_range(max_gap, 0)));
            end
            a = base + 32'(j) * 32'd4;
            exp_q.push_back('{a, w});
            n_chk++;
            if (we !== 1'b1 || waddr !== a || wdata !== w) begin
                n_fail++;
                $display("FAIL write_%0d: we=%b waddr=%h wdata=%h want 1 %h %h",
                         j, we, waddr, wdata, a, w);
            end
        end
        n_chk++;
        if (done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_csum: done=%b err=%b cpu_hold=%b want 0 0 1", done, err, cpu_hold);
        end
        drive_byte(xs + delta, int'($urandom_range(max_gap, 0)));
        n_chk++;
        if (err !== cs_fail) begin
            n_fail++;
            $display("FAIL csum_err: got %b want %b", err, cs_fail);
        end
        n_chk++;
        if (done !== (n == 0 && !cs_fail) || cpu_hold !== !(n == 0 && !cs_fail)
            || in_ready !== (n != 0 && !cs_fail)) begin
            n_fail++;
            $display("FAIL post_csum: done=%b cpu_hold=%b in_ready=%b n=%0d cs_fail=%b",
                     done, cpu_hold, in_ready, n, cs_fail);
        end
        n_chk++;
        if (got_q.size() != exp_q.size() || we_double != 0) begin
            n_fail++;
            $display("FAIL write_count: got %0d writes (%0d double) want %0d",
                     got_q.size(), we_double, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_chk++;
                if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) begin
                    n_fail++;
                    $display("FAIL scoreboard_%0d: got %h/%h want %h/%h",
                             i, got_q[i].a, got_q[i].d, exp_q[i].a, exp_q[i].d);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (in_ready !== 1'b1 || we !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b we=%b cpu_hold=%b done=%b err=%b want 1 0 1 0 0",
                     in_ready, we, cpu_hold, done, err);
        end
        n_chk++;
        if (waddr !== 32'd0 || wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: waddr=%h wdata=%h want 0 0", waddr, wdata);
        end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0]  pre[$];
        logic [31:0] w[$];
        do_reset();
        pre = '{8'hA5, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02,
                8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00};
        foreach (pre[i]) drive_byte(pre[i], 0);
        do_reset();
        n_chk++;
        if (waddr !== 32'd0 || wdata !== 32'd0 || we !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: waddr=%h wdata=%h we=%b in_ready=%b err=%b",
                     waddr, wdata, we, in_ready, err);
        end
        w = '{32'h2401_0005, 32'h0000_0000};
        send_frame(32'h0000_3000, 32'd2, w, 8'h00, 0);
        n_chk++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_hold: cpu_hold=%b want 1", cpu_hold);
        end
    endtask

    task automatic test_go();
        do_reset();
        send_frame(32'h0000_0000, 32'd0, none, 8'h00, 0);
        drive_byte(8'hA5, 0);
        drive_byte(8'h00, 0);
        n_chk++;
        if (in_ready !== 1'b0 || done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL go_sticky: in_ready=%b done=%b cpu_hold=%b err=%b want 0 1 0 0",
                     in_ready, done, cpu_hold, err);
        end
        do_reset();
        send_frame(32'h1234_5678, 32'd0, none, 8'h01, 0);
    endtask

    task automatic test_ktext_gaps();
        logic [31:0] w[$];
        do_reset();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        send_frame(32'h0000_4180, 32'd3, w, 8'h00, 4);
    endtask

    task automatic test_range_errors();
        logic [31:0] w[$];
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        do_reset();
        send_frame(32'h0000_2FFC, 32'd1, w, 8'h00, 0);
        do_reset();
        send_frame(32'h0000_6FFC, 32'd2, w, 8'h00, 0);
        do_reset();
        send_frame(32'h0000_3002, 32'd1, w, 8'h00, 0);
        do_reset();
        send_frame(32'hFFFF_FFFC, 32'hFFFF_FFFF, w, 8'h00, 0);
        do_reset();
        send_frame(32'h0000_6FFC, 32'd1, w, 8'h00, 1);
    endtask

    task automatic test_bad_csum();
        logic [31:0] w[$];
        do_reset();
        w.push_back($urandom);
        send_frame(32'h0000_3000 + 32'($urandom_range(4095, 0)) * 32'd4, 32'd1, w, 8'h01, 1);
        drive_byte(8'hA5, 0);
        n_chk++;
        if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || we !== 1'b0 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL badcsum_state: cpu_hold=%b in_ready=%b we=%b writes=%0d want 1 0 0 1",
                     cpu_hold, in_ready, we, got_q.size());
        end
    endtask

    task automatic test_garbage();
        logic [31:0] w[$];
        logic [7:0]  g[$];
        do_reset();
        g = '{8'h00, 8'hFF, 8'h5A};
        foreach (g[i]) drive_byte(g[i], 0);
        n_chk++;
        if (in_ready !== 1'b1 || err !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL garbage: in_ready=%b err=%b writes=%0d want 1 0 0",
                     in_ready, err, got_q.size());
        end
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        send_frame(32'h0000_5000, 32'd2, w, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[$];
        int unsigned nw;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            w.delete();
            nw = $urandom_range(5, 1);
            for (int unsigned i = 0; i < nw; i++) w.push_back($urandom);
            send_frame(32'h0000_3000 + 32'($urandom_range(4096 - nw, 0)) * 32'd4,
                       32'(nw), w, 8'h00, int'($urandom_range(2, 0)));
        end
        send_frame(32'h0000_0000, 32'd0, none, 8'h00, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        n_chk     = 0;
        n_fail    = 0;
        we_double = 0;
        prev_we   = 1'b0;
        test_reset();
        test_reset_mid_data();
        test_go();
        test_ktext_gaps();
        test_range_errors();
        test_bad_csum();
        test_garbage();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
